// File: rtl/mac_pe_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pe_pipe
//  Description : Pipelined multiply-accumulate processing element for a
//                systolic matrix multiplier. Forwards operands east/south,
//                accumulates signed/unsigned products and presents finished
//                dot products on a valid/ready result port.
//                Optional feature macro: MAC_PE_SAT_EN (saturating add).
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_pe_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  first_i,
  input  logic                  last_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  fwd_valid_o,
  output logic [ACC_WIDTH-1:0]  res_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  res_sat_o,
  output logic                  overrun_o
);

  localparam int c_PROD_W = 2*DATA_WIDTH;

  // Forward-stage registers
  logic [DATA_WIDTH-1:0] r_a_fwd;
  logic [DATA_WIDTH-1:0] r_b_fwd;
  logic                  r_fwd_valid;

  // Product-stage registers
  logic [c_PROD_W-1:0]   r_p;
  logic                  r_p_valid;
  logic                  r_p_first;
  logic                  r_p_last;
  logic                  r_p_signed;

  // Accumulator and result registers
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_res;
  logic                  r_res_valid;
  logic                  r_overrun;

  // Combinational datapath
  logic [c_PROD_W-1:0]   w_a_ext;
  logic [c_PROD_W-1:0]   w_b_ext;
  logic [c_PROD_W-1:0]   w_prod;
  logic [ACC_WIDTH-1:0]  w_p_ext;
  logic [ACC_WIDTH-1:0]  w_base;
  logic [ACC_WIDTH-1:0]  w_acc_next;
  logic                  w_new_res;

  // Extending both operands to the product width makes the low 2*DATA_WIDTH
  // bits of a single multiplier correct for both signed and unsigned modes.
  assign w_a_ext = {{DATA_WIDTH{signed_i & a_i[DATA_WIDTH-1]}}, a_i};
  assign w_b_ext = {{DATA_WIDTH{signed_i & b_i[DATA_WIDTH-1]}}, b_i};
  assign w_prod  = w_a_ext * w_b_ext;

  // Extend the registered product to accumulator width using its own tag.
  generate
    if (ACC_WIDTH > c_PROD_W) begin : g_ext_wide
      assign w_p_ext = {{(ACC_WIDTH-c_PROD_W){r_p_signed & r_p[c_PROD_W-1]}}, r_p};
    end else begin : g_ext_exact
      assign w_p_ext = r_p;
    end
  endgenerate

  // A first term restarts the sum from zero rather than the old accumulator.
  assign w_base    = r_p_first ? '0 : r_acc;
  assign w_new_res = r_p_valid & r_p_last;

`ifdef MAC_PE_SAT_EN
  logic [ACC_WIDTH:0]    w_sum_wide;
  logic                  w_clamp;
  logic                  w_sat_next;
  logic                  r_sat;
  logic                  r_res_sat;

  assign w_sum_wide = {1'b0, w_base} + {1'b0, w_p_ext};

  // Clamp to the signed or unsigned range selected by the product's tag.
  always_comb begin
    w_acc_next = w_sum_wide[ACC_WIDTH-1:0];
    w_clamp    = 1'b0;
    if (r_p_signed) begin
      if ((w_base[ACC_WIDTH-1] == w_p_ext[ACC_WIDTH-1]) &&
          (w_sum_wide[ACC_WIDTH-1] != w_base[ACC_WIDTH-1])) begin
        w_clamp    = 1'b1;
        w_acc_next = w_base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else if (w_sum_wide[ACC_WIDTH]) begin
      w_clamp    = 1'b1;
      w_acc_next = '1;
    end
  end

  // Sequence saturation flag restarts on each first term.
  assign w_sat_next = w_clamp | (~r_p_first & r_sat);

  // Sequence and result saturation flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat     <= 1'b0;
      r_res_sat <= 1'b0;
    end else if (r_p_valid) begin
      r_sat <= w_sat_next;
      if (r_p_last) r_res_sat <= w_sat_next;
    end
  end

  assign res_sat_o = r_res_sat;
`else
  // Plain modulo-2^ACC_WIDTH accumulation.
  assign w_acc_next = w_base + w_p_ext;
  assign res_sat_o  = 1'b0;
`endif

  // Operand forwarding to neighbours; operands hold during gaps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_fwd     <= '0;
      r_b_fwd     <= '0;
      r_fwd_valid <= 1'b0;
    end else begin
      r_fwd_valid <= in_valid;
      if (in_valid) begin
        r_a_fwd <= a_i;
        r_b_fwd <= b_i;
      end
    end
  end

  // Product stage with its sequencing tags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p        <= '0;
      r_p_valid  <= 1'b0;
      r_p_first  <= 1'b0;
      r_p_last   <= 1'b0;
      r_p_signed <= 1'b0;
    end else begin
      r_p_valid <= in_valid;
      if (in_valid) begin
        r_p        <= w_prod;
        r_p_first  <= first_i;
        r_p_last   <= last_i;
        r_p_signed <= signed_i;
      end
    end
  end

  // Accumulator advances only on valid products
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (r_p_valid) begin
      r_acc <= w_acc_next;
    end
  end

  // Result register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_new_res) begin
      r_res       <= w_acc_next;
      r_res_valid <= 1'b1;
      if (r_res_valid && !res_ready_i) r_overrun <= 1'b1;
    end else if (r_res_valid && res_ready_i) begin
      r_res_valid <= 1'b0;
    end
  end

  assign a_o         = r_a_fwd;
  assign b_o         = r_b_fwd;
  assign fwd_valid_o = r_fwd_valid;
  assign res_o       = r_res;
  assign res_valid_o = r_res_valid;
  assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mac_pe_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_pe_pipe
//  Description : Self-checking bench for mac_pe_pipe (24-bit and 16-bit
//                accumulator instances sharing one stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_pe_pipe;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        first_i;
  logic        last_i;
  logic        signed_i;
  logic        res_ready_i;

  logic [7:0]  a_o;
  logic [7:0]  b_o;
  logic        fwd_valid_o;
  logic [23:0] res_o;
  logic        res_valid_o;
  logic        res_sat_o;
  logic        overrun_o;

  logic [7:0]  a2_o;
  logic [7:0]  b2_o;
  logic        fwd2_valid_o;
  logic [15:0] res2_o;
  logic        res2_valid_o;
  logic        res2_sat_o;
  logic        overrun2_o;

  int checks;
  int failures;

  mac_pe_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(24)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .a_i(a_i), .b_i(b_i), .first_i(first_i), .last_i(last_i),
    .signed_i(signed_i), .a_o(a_o), .b_o(b_o), .fwd_valid_o(fwd_valid_o),
    .res_o(res_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_sat_o(res_sat_o), .overrun_o(overrun_o)
  );

  mac_pe_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .a_i(a_i), .b_i(b_i), .first_i(first_i), .last_i(last_i),
    .signed_i(signed_i), .a_o(a2_o), .b_o(b2_o), .fwd_valid_o(fwd2_valid_o),
    .res_o(res2_o), .res_valid_o(res2_valid_o), .res_ready_i(res_ready_i),
    .res_sat_o(res2_sat_o), .overrun_o(overrun2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        f;
    logic        l;
    logic        s;
    logic        rdy;
    logic        efv;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        erv;
    logic [23:0] eres;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic v, input logic [7:0] a, input logic [7:0] b,
                              input logic f, input logic l, input logic s, input logic rdy,
                              input logic efv, input logic [7:0] ea, input logic [7:0] eb,
                              input logic erv, input logic [23:0] eres);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.f = f; t.l = l; t.s = s; t.rdy = rdy;
    t.efv = efv; t.ea = ea; t.eb = eb; t.erv = erv; t.eres = eres;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample after the rising edge.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic f, input logic l, input logic s, input logic rdy);
    @(negedge clk);
    in_valid = v; a_i = a; b_i = b; first_i = f; last_i = l; signed_i = s;
    res_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_o"},        {24'd0, a_o},         32'd0);
    chk({tag, "_b_o"},        {24'd0, b_o},         32'd0);
    chk({tag, "_fwd_valid"},  {31'd0, fwd_valid_o}, 32'd0);
    chk({tag, "_res"},        {8'd0, res_o},        32'd0);
    chk({tag, "_res_valid"},  {31'd0, res_valid_o}, 32'd0);
    chk({tag, "_res_sat"},    {31'd0, res_sat_o},   32'd0);
    chk({tag, "_overrun"},    {31'd0, overrun_o},   32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b0; first_i = 1'b0; last_i = 1'b0; res_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n = 1'b0; in_valid = 1'b0; a_i = '0; b_i = '0;
    first_i = 1'b0; last_i = 1'b0; signed_i = 1'b0; res_ready_i = 1'b1;

    //          v  a      b      f  l  s  rdy | fv a_o    b_o    rv res
    tbl[0]  = mk(1, 8'd3,  8'd4,  1, 0, 0, 1,   1, 8'd3,  8'd4,  0, 24'd0);
    tbl[1]  = mk(1, 8'd5,  8'd6,  0, 0, 0, 1,   1, 8'd5,  8'd6,  0, 24'd0);
    tbl[2]  = mk(1, 8'hFF, 8'hFF, 0, 1, 0, 1,   1, 8'hFF, 8'hFF, 0, 24'd0);
    tbl[3]  = mk(0, 8'hFF, 8'hFF, 0, 0, 0, 1,   0, 8'hFF, 8'hFF, 1, 24'd65067);
    tbl[4]  = mk(0, 8'hFF, 8'hFF, 0, 0, 0, 1,   0, 8'hFF, 8'hFF, 0, 24'd65067);
    tbl[5]  = mk(1, 8'h80, 8'h7F, 1, 0, 1, 1,   1, 8'h80, 8'h7F, 0, 24'd65067);
    tbl[6]  = mk(1, 8'hFF, 8'hFF, 0, 1, 1, 1,   1, 8'hFF, 8'hFF, 0, 24'd65067);
    tbl[7]  = mk(1, 8'h80, 8'h7F, 1, 1, 0, 1,   1, 8'h80, 8'h7F, 1, 24'hFFC081);
    tbl[8]  = mk(0, 8'h80, 8'h7F, 0, 0, 0, 1,   0, 8'h80, 8'h7F, 1, 24'd16256);
    tbl[9]  = mk(0, 8'h80, 8'h7F, 0, 0, 0, 1,   0, 8'h80, 8'h7F, 0, 24'd16256);
    tbl[10] = mk(1, 8'd1,  8'd1,  1, 0, 0, 1,   1, 8'd1,  8'd1,  0, 24'd16256);
    tbl[11] = mk(0, 8'd9,  8'd9,  0, 0, 0, 1,   0, 8'd1,  8'd1,  0, 24'd16256);
    tbl[12] = mk(0, 8'd9,  8'd9,  0, 1, 0, 1,   0, 8'd1,  8'd1,  0, 24'd16256);
    tbl[13] = mk(1, 8'd2,  8'd2,  0, 1, 0, 1,   1, 8'd2,  8'd2,  0, 24'd16256);
    tbl[14] = mk(0, 8'd2,  8'd2,  0, 0, 0, 1,   0, 8'd2,  8'd2,  1, 24'd5);
    tbl[15] = mk(0, 8'd2,  8'd2,  0, 0, 0, 1,   0, 8'd2,  8'd2,  0, 24'd5);
    tbl[16] = mk(1, 8'd2,  8'd3,  1, 1, 0, 0,   1, 8'd2,  8'd3,  0, 24'd5);
    tbl[17] = mk(0, 8'd2,  8'd3,  0, 0, 0, 0,   0, 8'd2,  8'd3,  1, 24'd6);
    tbl[18] = mk(0, 8'd2,  8'd3,  0, 0, 0, 0,   0, 8'd2,  8'd3,  1, 24'd6);
    tbl[19] = mk(0, 8'd2,  8'd3,  0, 0, 0, 1,   0, 8'd2,  8'd3,  0, 24'd6);

    // Reset state
    #1;
    check_all_zero("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven: unsigned/signed dot products, gaps and handshake
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].l, tbl[i].s, tbl[i].rdy);
      chk($sformatf("row%0d_fwd_valid", i), {31'd0, fwd_valid_o}, {31'd0, tbl[i].efv});
      chk($sformatf("row%0d_a_o", i),       {24'd0, a_o},         {24'd0, tbl[i].ea});
      chk($sformatf("row%0d_b_o", i),       {24'd0, b_o},         {24'd0, tbl[i].eb});
      chk($sformatf("row%0d_res_valid", i), {31'd0, res_valid_o}, {31'd0, tbl[i].erv});
      chk($sformatf("row%0d_res", i),       {8'd0, res_o},        {8'd0, tbl[i].eres});
      chk($sformatf("row%0d_overrun", i),   {31'd0, overrun_o},   32'd0);
      chk($sformatf("row%0d_res_sat", i),   {31'd0, res_sat_o},   32'd0);
    end

    // Back-to-back single-term results with no consumer: overrun
    do_reset();
    drive(1, 8'd2, 8'd2, 1, 1, 0, 0);
    drive(1, 8'd3, 8'd3, 1, 1, 0, 0);
    chk("b2b_a_res",       {8'd0, res_o},        32'd4);
    chk("b2b_a_valid",     {31'd0, res_valid_o}, 32'd1);
    drive(0, 8'd3, 8'd3, 0, 0, 0, 0);
    chk("b2b_b_res",       {8'd0, res_o},        32'd9);
    chk("b2b_b_valid",     {31'd0, res_valid_o}, 32'd1);
    chk("b2b_overrun",     {31'd0, overrun_o},   32'd1);
    drive(0, 8'd3, 8'd3, 0, 0, 0, 1);
    chk("b2b_overrun_sticky", {31'd0, overrun_o},  32'd1);
    chk("b2b_consumed",       {31'd0, res_valid_o}, 32'd0);

    // Consumer accepts in the same cycle the next result lands: no overrun
    do_reset();
    drive(1, 8'd2, 8'd2, 1, 1, 0, 0);
    drive(1, 8'd3, 8'd3, 1, 1, 0, 0);
    drive(0, 8'd3, 8'd3, 0, 0, 0, 1);
    chk("accept_res",      {8'd0, res_o},        32'd9);
    chk("accept_valid",    {31'd0, res_valid_o}, 32'd1);
    chk("accept_overrun",  {31'd0, overrun_o},   32'd0);

    // Reset mid-sequence, then a fresh single-term product
    drive(1, 8'd5, 8'd5, 1, 0, 0, 1);
    drive(1, 8'd6, 8'd6, 0, 0, 0, 1);
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0;
    #1;
    check_all_zero("midreset_async");
    @(posedge clk);
    #1;
    check_all_zero("midreset_held");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 8'd7, 8'd7, 1, 1, 0, 1);
    chk("post_reset_idle_valid", {31'd0, res_valid_o}, 32'd0);
    drive(0, 8'd7, 8'd7, 0, 0, 0, 1);
    chk("post_reset_res",   {8'd0, res_o},        32'd49);
    chk("post_reset_valid", {31'd0, res_valid_o}, 32'd1);

    // Narrow accumulator overflow: wrap or saturate depending on build
    do_reset();
    drive(1, 8'hFF, 8'hFF, 1, 0, 0, 1);
    drive(1, 8'hFF, 8'hFF, 0, 1, 0, 1);
    drive(0, 8'hFF, 8'hFF, 0, 0, 0, 1);
    chk("wide_res",     {8'd0, res_o},         32'h1FC02);
    chk("wide_sat",     {31'd0, res_sat_o},    32'd0);
    chk("narrow_valid", {31'd0, res2_valid_o}, 32'd1);
`ifdef MAC_PE_SAT_EN
    chk("narrow_res",   {16'd0, res2_o},       32'hFFFF);
    chk("narrow_sat",   {31'd0, res2_sat_o},   32'd1);
`else
    chk("narrow_res",   {16'd0, res2_o},       32'hFC02);
    chk("narrow_sat",   {31'd0, res2_sat_o},   32'd0);
`endif
    // A following unsaturated sequence clears the flag
    drive(1, 8'd1, 8'd1, 1, 1, 0, 1);
    drive(0, 8'd1, 8'd1, 0, 0, 0, 1);
    chk("narrow_res2",  {16'd0, res2_o},       32'd1);
    chk("narrow_sat2",  {31'd0, res2_sat_o},   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
